// File: rtl/lb_pkg.sv
// Shared types and constants for the rotating 4-BRAM line buffer and its scheduler.
package lb_pkg;

    localparam int unsigned NUM_BUF     = 4;
    localparam int unsigned LB_SEL_W    = 2;
    localparam int unsigned HCNT_W      = 11;
    localparam int unsigned VCNT_W      = 10;
    localparam int unsigned LR_W        = 8;
    localparam int unsigned DEF_HRES    = 1280;
    localparam int unsigned DEF_VRES    = 720;
    localparam int unsigned DEF_KERNEL  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } lb_state_t;

    // Window metadata that travels alongside the BRAM read latency.
    typedef struct packed {
        logic                valid;
        logic [HCNT_W-1:0]   hcount;
        logic [VCNT_W-1:0]   vcount;
        logic [LB_SEL_W-1:0] rot;
    } lb_win_t;

endpackage

// File: rtl/lb_sched_delay.sv
// Two-stage register pipeline used to align scheduler metadata with BRAM read data.
module lb_sched_delay #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] q_out
);

    logic [W-1:0] s1_q, s1_d;
    logic [W-1:0] s2_q, s2_d;

    always_comb begin
        s1_d = d_in;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q_out = s2_q;

endmodule

// File: rtl/line_buffer_sched.sv
// Frame/line sequencer for the rotating line buffer feeding the 3x3 convolution.
// Optional frame/error statistics counters are enabled with LB_SCHED_STATS_EN.
module line_buffer_sched
    import lb_pkg::*;
#(
    parameter int unsigned HRES        = DEF_HRES,
    parameter int unsigned VRES        = DEF_VRES,
    parameter int unsigned KERNEL_SIZE = DEF_KERNEL
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic [HCNT_W-1:0]   hcount_in,
    input  logic [VCNT_W-1:0]   vcount_in,
    input  logic                data_valid_in,
    output logic [NUM_BUF-1:0]  write_en_out,
    output logic [LB_SEL_W-1:0] write_sel_out,
    output logic [LB_SEL_W-1:0] rot_out,
    output logic                window_valid_out,
    output logic [HCNT_W-1:0]   hcount_out,
    output logic [VCNT_W-1:0]   vcount_out,
    output logic                sync_err_out,
    output logic                frame_done_out,
    output logic [15:0]         frame_count_out,
    output logic [7:0]          err_count_out
);

    localparam logic [HCNT_W-1:0] H_LAST = HCNT_W'(HRES - 1);
    localparam logic [VCNT_W-1:0] V_LAST = VCNT_W'(VRES - 1);
    localparam logic [LR_W-1:0]   LR_RUN = LR_W'(KERNEL_SIZE - 1);

    lb_state_t           state_q, state_d;
    logic [LB_SEL_W-1:0] write_sel_q, write_sel_d;
    logic [LR_W-1:0]     lines_ready_q, lines_ready_d;
    logic [HCNT_W-1:0]   expected_h_q, expected_h_d;
    logic                sync_err_q, sync_err_d;
    logic                frame_done_q, frame_done_d;

    logic    sof, desync, accepted, eol;
    lb_win_t win_in, win_out;

    // Pixel classification and next-state computation.
    always_comb begin
        state_d       = state_q;
        write_sel_d   = write_sel_q;
        lines_ready_d = lines_ready_q;
        expected_h_d  = expected_h_q;
        sync_err_d    = 1'b0;
        frame_done_d  = 1'b0;

        sof      = data_valid_in && (hcount_in == '0) && (vcount_in == '0);
        desync   = data_valid_in && (state_q != IDLE) && !sof && (hcount_in != expected_h_q);
        accepted = sof || (data_valid_in && (state_q != IDLE) && !desync);
        eol      = accepted && (hcount_in == H_LAST);

        if (sof) begin
            state_d       = FILL;
            lines_ready_d = '0;
            expected_h_d  = (hcount_in == H_LAST) ? '0 : HCNT_W'(1);
            sync_err_d    = (state_q != IDLE);
        end else if (desync) begin
            state_d       = IDLE;
            lines_ready_d = '0;
            expected_h_d  = '0;
            sync_err_d    = 1'b1;
        end else if (accepted) begin
            expected_h_d  = (hcount_in == H_LAST) ? '0 : HCNT_W'(expected_h_q + HCNT_W'(1));
        end

        if (eol) begin
            write_sel_d = LB_SEL_W'(write_sel_q + LB_SEL_W'(1));
            if (state_d == FILL) begin
                lines_ready_d = LR_W'(lines_ready_d + LR_W'(1));
                if (lines_ready_d == LR_RUN) begin
                    state_d = RUN;
                end
            end else if ((state_d == RUN) && (vcount_in == V_LAST)) begin
                frame_done_d  = 1'b1;
                state_d       = IDLE;
                lines_ready_d = '0;
                expected_h_d  = '0;
            end
        end

        write_en_out = accepted ? (NUM_BUF'(1) << write_sel_q) : '0;

        // The frame-start pixel sits on row 0 and never forms a window.
        win_in.valid  = accepted && (state_q == RUN) && !sof;
        win_in.hcount = hcount_in;
        win_in.vcount = VCNT_W'(vcount_in - VCNT_W'(1));
        win_in.rot    = write_sel_q;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= IDLE;
            write_sel_q   <= '0;
            lines_ready_q <= '0;
            expected_h_q  <= '0;
            sync_err_q    <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            write_sel_q   <= write_sel_d;
            lines_ready_q <= lines_ready_d;
            expected_h_q  <= expected_h_d;
            sync_err_q    <= sync_err_d;
            frame_done_q  <= frame_done_d;
        end
    end

    lb_sched_delay #(
        .W ($bits(lb_win_t))
    ) u_delay (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .d_in  (win_in),
        .q_out (win_out)
    );

    assign write_sel_out    = write_sel_q;
    assign sync_err_out     = sync_err_q;
    assign frame_done_out   = frame_done_q;
    assign window_valid_out = win_out.valid;
    assign hcount_out       = win_out.hcount;
    assign vcount_out       = win_out.vcount;
    assign rot_out          = win_out.rot;

`ifdef LB_SCHED_STATS_EN
    logic [15:0] frame_count_q, frame_count_d;
    logic [7:0]  err_count_q, err_count_d;

    // Counters update together with the pulse they count.
    always_comb begin
        frame_count_d = frame_count_q;
        err_count_d   = err_count_q;
        if (frame_done_d) begin
            frame_count_d = frame_count_q + 16'd1;
        end
        if (sync_err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            frame_count_q <= '0;
            err_count_q   <= '0;
        end else begin
            frame_count_q <= frame_count_d;
            err_count_q   <= err_count_d;
        end
    end

    assign frame_count_out = frame_count_q;
    assign err_count_out   = err_count_q;
`else
    assign frame_count_out = '0;
    assign err_count_out   = '0;
`endif

endmodule

// File: tb/tb_line_buffer_sched.sv
// Self-checking bench for line_buffer_sched (HRES=8, VRES=6) against a frame-level model.
module tb_line_buffer_sched;

    localparam int HRES = 8;
    localparam int VRES = 6;
    localparam int K    = 3;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        data_valid_in;
    logic [3:0]  write_en_out;
    logic [1:0]  write_sel_out;
    logic [1:0]  rot_out;
    logic        window_valid_out;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic        sync_err_out;
    logic        frame_done_out;
    logic [15:0] frame_count_out;
    logic [7:0]  err_count_out;

    line_buffer_sched #(.HRES(HRES), .VRES(VRES), .KERNEL_SIZE(K)) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .hcount_in        (hcount_in),
        .vcount_in        (vcount_in),
        .data_valid_in    (data_valid_in),
        .write_en_out     (write_en_out),
        .write_sel_out    (write_sel_out),
        .rot_out          (rot_out),
        .window_valid_out (window_valid_out),
        .hcount_out       (hcount_out),
        .vcount_out       (vcount_out),
        .sync_err_out     (sync_err_out),
        .frame_done_out   (frame_done_out),
        .frame_count_out  (frame_count_out),
        .err_count_out    (err_count_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Frame-level reference: a frame is open or not, lines completed, next column, buffer pointer.
    bit m_in_frame;
    int m_lines_done;
    int m_next_col;
    int m_buf;
    int m_frames;
    int m_errs;
    bit prev_wv;
    int prev_h, prev_v, prev_rot;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_in_frame   = 0;
        m_lines_done = 0;
        m_next_col   = 0;
        m_buf        = 0;
        m_frames     = 0;
        m_errs       = 0;
        prev_wv      = 0;
        prev_h       = 0;
        prev_v       = 0;
        prev_rot     = 0;
    endtask

    task automatic chk_stats();
`ifdef LB_SCHED_STATS_EN
        chk("frame_count", 32'(frame_count_out), 32'(m_frames % 65536));
        chk("err_count", 32'(err_count_out), 32'(m_errs > 255 ? 255 : m_errs));
`else
        chk("frame_count", 32'(frame_count_out), 32'd0);
        chk("err_count", 32'(err_count_out), 32'd0);
`endif
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_write_en"}, 32'(write_en_out), 32'd0);
        chk({tag, "_write_sel"}, 32'(write_sel_out), 32'd0);
        chk({tag, "_rot"}, 32'(rot_out), 32'd0);
        chk({tag, "_window_valid"}, 32'(window_valid_out), 32'd0);
        chk({tag, "_hcount"}, 32'(hcount_out), 32'd0);
        chk({tag, "_vcount"}, 32'(vcount_out), 32'd0);
        chk({tag, "_sync_err"}, 32'(sync_err_out), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done_out), 32'd0);
        chk({tag, "_frame_count"}, 32'(frame_count_out), 32'd0);
        chk({tag, "_err_count"}, 32'(err_count_out), 32'd0);
    endtask

    // One clock cycle: drive a pixel, check the same-cycle enable, then the registered outputs.
    task automatic step(input bit valid, input int h, input int v);
        bit acc, err, done, wv;
        int rot, wen;
        acc = 0; err = 0; done = 0; wv = 0;
        rot = m_buf;
        data_valid_in = valid;
        hcount_in     = 11'(h);
        vcount_in     = 10'(v);
        if (valid) begin
            if (h == 0 && v == 0) begin
                err = m_in_frame;
                acc = 1;
                m_in_frame   = 1;
                m_lines_done = 0;
                m_next_col   = 1 % HRES;
            end else if (m_in_frame) begin
                if (h != m_next_col) begin
                    err = 1;
                    m_in_frame = 0;
                end else begin
                    acc = 1;
                    wv  = (m_lines_done >= K - 1);
                    m_next_col = (h + 1) % HRES;
                end
            end
            if (acc && h == HRES - 1) begin
                m_buf = (m_buf + 1) % 4;
                if (m_lines_done < K - 1) m_lines_done++;
                else if (v == VRES - 1) begin
                    done = 1;
                    m_in_frame = 0;
                end
            end
        end
        if (err) m_errs++;
        if (done) m_frames++;
        wen = acc ? (1 << rot) : 0;
        #1;
        chk("write_en", 32'(write_en_out), 32'(wen));
        @(posedge clk_in);
        #1;
        chk("sync_err", 32'(sync_err_out), 32'(err));
        chk("frame_done", 32'(frame_done_out), 32'(done));
        chk("write_sel", 32'(write_sel_out), 32'(m_buf));
        chk("window_valid", 32'(window_valid_out), 32'(prev_wv));
        if (prev_wv) begin
            chk("hcount_out", 32'(hcount_out), 32'(prev_h));
            chk("vcount_out", 32'(vcount_out), 32'(prev_v - 1));
            chk("rot_out", 32'(rot_out), 32'(prev_rot));
        end
        chk_stats();
        prev_wv  = wv;
        prev_h   = h;
        prev_v   = v;
        prev_rot = rot;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, int'($urandom_range(0, HRES - 1)), int'($urandom_range(0, VRES - 1)));
    endtask

    // Raster-order pixels up to (last_v,last_h), optionally dropping one pixel and adding random gaps.
    task automatic frame_part(input int last_v, input int last_h, input bit gap,
                              input int skip_v, input int skip_h);
        for (int v = 0; v < VRES; v++) begin
            for (int h = 0; h < HRES; h++) begin
                if (v > last_v || (v == last_v && h > last_h)) return;
                if (!(v == skip_v && h == skip_h)) begin
                    if (gap) idle(int'($urandom_range(0, 2)));
                    step(1, h, v);
                end
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rst_n_in      = 1'b0;
        data_valid_in = 1'b0;
        hcount_in     = '0;
        vcount_in     = '0;
        repeat (3) @(posedge clk_in);
        #1;
        chk_all_zero("reset");
        rst_n_in = 1'b1;
        idle(3);

        // Continuous full frame, then a gapped one.
        frame_part(VRES - 1, HRES - 1, 0, -1, -1);
        idle(3);
        frame_part(VRES - 1, HRES - 1, 1, -1, -1);
        idle(3);

        // Dropped pixel in RUN: the rest of the frame is ignored until the next start.
        frame_part(VRES - 1, HRES - 1, 0, 3, 4);
        idle(2);

        // Frame start arriving mid-frame restarts filling.
        frame_part(4, 2, 0, -1, -1);
        frame_part(VRES - 1, HRES - 1, 0, -1, -1);
        idle(2);

        // Randomly gapped frames with a random dropped pixel.
        for (int f = 0; f < 3; f++) begin
            frame_part(VRES - 1, HRES - 1, 1, int'($urandom_range(0, VRES - 1)), int'($urandom_range(1, HRES - 1)));
            frame_part(VRES - 1, HRES - 1, 1, -1, -1);
            idle(2);
        end

        // Asynchronous reset mid-row while in RUN.
        frame_part(3, 3, 0, -1, -1);
        data_valid_in = 1'b1;
        hcount_in     = 11'd4;
        vcount_in     = 10'd3;
        #3;
        rst_n_in = 1'b0;
        #1;
        chk_all_zero("async_reset");
        model_reset();
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        data_valid_in = 1'b0;
        rst_n_in      = 1'b1;
        idle(2);
        frame_part(VRES - 1, HRES - 1, 0, -1, -1);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_buffer_sched.md
Name: line_buffer_sched

Overview:
Controller that sequences the 4-BRAM rotating line buffer used by the 3x3 convolution path.
- Tracks frame and line position from the pixel stream.
- Generates one-hot BRAM write enables and the read-rotation index, delayed to match BRAM read latency.
- Suppresses kernel windows until enough rows exist.
- Detects stream desynchronisation and resynchronises on the next frame start.

Parameters:
- HRES, 1280, active pixels per line.
- VRES, 720, active lines per frame.
- KERNEL_SIZE, 3, kernel rows. Buffer count NUM_BUF = KERNEL_SIZE+1 is a fixed localparam, not overridable.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  reset, asynchronous, active-low
- hcount_in  input  11  column of incoming pixel
- vcount_in  input  10  row of incoming pixel
- data_valid_in  input  1  incoming pixel valid
- write_en_out  output  4  one-hot BRAM write enable (combinational)
- write_sel_out  output  2  index of BRAM being written
- rot_out  output  2  read-mux rotation, aligned with BRAM output
- window_valid_out  output  1  full kernel window available, aligned with BRAM output
- hcount_out  output  11  column of window centre
- vcount_out  output  10  row of window centre
- sync_err_out  output  1  one-cycle pulse on desync
- frame_done_out  output  1  one-cycle pulse after last pixel of frame
- frame_count_out  output  16  frames completed (see Optional Feature)
- err_count_out  output  8  sync errors (see Optional Feature)

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, write_sel=0, lines_ready=0, expected_h=0.
  - All registered outputs 0; pipeline valids cleared.
- Accepted pixel = data_valid_in && state!=IDLE, or the (0,0) pixel that starts a frame from IDLE.
- write_en_out = accepted ? (1<<write_sel) : 0. Combinational, same cycle as the pixel.
- FSM states IDLE, FILL, RUN. Priority order per valid pixel:
  1. hcount_in==0 && vcount_in==0:
     - From IDLE: go to FILL; lines_ready=0; pixel written.
     - From FILL/RUN: resync. sync_err_out pulses; restart FILL with lines_ready=0; pixel written.
  2. state!=IDLE && hcount_in!=expected_h: sync_err_out pulses; go to IDLE; pixel not written; lines_ready=0.
  3. Otherwise, in FILL/RUN: expected_h increments, wrapping HRES-1 -> 0.
- End of line = accepted pixel with hcount_in==HRES-1:
  - write_sel increments mod 4.
  - FILL: lines_ready increments. When it reaches KERNEL_SIZE-1, go to RUN.
  - RUN with vcount_in==VRES-1: frame_done_out pulses next cycle; go to IDLE; lines_ready=0. write_sel still increments.
- data_valid_in low: no state change; gaps of any length inside a line are legal.
- In IDLE, valid pixels other than (0,0) are ignored silently.
- Output latency is exactly 2 cycles, matching the BRAM HIGH_PERFORMANCE read latency. Pixel at cycle t gives, at t+2:
  - window_valid_out = accepted && state==RUN at t.
  - hcount_out = hcount_in.
  - vcount_out = vcount_in-1 (centre row; always >=1 when window_valid_out=1).
  - rot_out = write_sel at t.
- The first KERNEL_SIZE-1 lines of each frame never assert window_valid_out. No vertical wrap-around.
- Reset asserted mid-frame: immediate return to reset values; no frame_done_out or sync_err_out pulse.

Optional Feature:
- Macro LB_SCHED_STATS_EN.
- Defined:
  - frame_count_out increments on each frame_done_out, wrapping at 2^16.
  - err_count_out increments on each sync_err_out, saturating at 255.
  - Both reset to 0.
- Undefined: both ports remain in the interface, tied to 0, and no counter logic is generated.

Decomposition:
- Package lb_pkg holds:
  - lb_state_t enum {IDLE, FILL, RUN}.
  - NUM_BUF=4 and LB_SEL_W=2.
  - Default HRES/VRES constants shared with line_buffer.
- One sub-module: lb_sched_delay, a parameterised-width 2-stage register pipeline with async active-low reset. It carries the valid, hcount, vcount and rotation fields.

Test Plan:
- Reset values: rst_n_in=0 held 3 cycles -> every output 0 and write_en_out=0. Release gives no spurious pulse.
- Full frame with HRES=8, VRES=6, continuous valid:
  - write_en_out sequence 0001 x8, 0010 x8, 0100 x8, 1000 x8, 0001…
  - window_valid_out first high 2 cycles after pixel (0,2), with vcount_out=1, hcount_out=0.
  - frame_done_out pulses once after (7,5); frame_count_out=1 when macro defined.
- Gapped stream: valid toggled 1/0 across the same frame -> identical output sequence, compressed to valid cycles only, with every latency still 2.
- Desync: skip pixel hcount=4 on row 3 -> sync_err_out pulse; IDLE; write_en_out=0 until the next (0,0); err_count_out=1.
- Mid-frame restart: pixel (0,0) arrives at row 4 -> sync_err_out pulse; lines_ready=0; windows suppressed for rows 0-1 of the new frame.
- Async reset asserted mid-row in RUN -> outputs clear within the same cycle; next (0,0) restarts with write_sel=0.
